// File: rtl/e203_itcm_ctrl_pkg.sv
// Shared widths and encodings for the ITCM controller slice.
package e203_itcm_ctrl_pkg;
  localparam int E203_ITCM_RAM_AW = 13;
  localparam int E203_ITCM_RAM_DW = 64;
  localparam int E203_ITCM_RAM_MW = 8;

  typedef enum logic {OWN_IFU = 1'b0, OWN_LSU = 1'b1} owner_e;
  typedef enum logic {IDLE = 1'b0, PEND = 1'b1} state_e;

  // Bookkeeping for the single access in flight.
  typedef struct packed {
    state_e st;
    owner_e own;
    logic   rd;
  } pend_t;
endpackage

// File: rtl/e203_itcm_ls_ctrl.sv
// Idle counter and light-sleep / wake sequencing for the ITCM RAM.
module e203_itcm_ls_ctrl #(
  parameter int IDLE_LS = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic quiet_i,  // controller IDLE and no cs this cycle
  input  logic wake_i,   // any requester valid
  output logic ls_o,     // sleeping: blocks issue this cycle
  output logic ram_ls_o
);
  import e203_itcm_ctrl_pkg::*;

  localparam int CW = (IDLE_LS > 0) ? $clog2(IDLE_LS + 1) : 1;
  localparam logic [CW-1:0] LIM = CW'(IDLE_LS);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!quiet_i || wake_i)
      cnt_d = '0;
    else if ((IDLE_LS != 0) && (cnt_q != LIM))
      cnt_d = cnt_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  // The pin drops as soon as a request shows up; issue stays blocked
  // until the counter has cleared on the following cycle.
  assign ls_o     = (IDLE_LS != 0) && (cnt_q == LIM);
  assign ram_ls_o = ls_o && !wake_i;
endmodule

// File: rtl/e203_itcm_ctrl.sv
// ITCM SRAM sequencer: LSU-priority arbitration with IFU anti-starvation,
// 1-cycle read response routing and light-sleep control.
module e203_itcm_ctrl
  import e203_itcm_ctrl_pkg::*;
#(
  parameter int AW         = E203_ITCM_RAM_AW,
  parameter int DW         = E203_ITCM_RAM_DW,
  parameter int MW         = E203_ITCM_RAM_MW,
  parameter int STARVE_MAX = 4,
  parameter int IDLE_LS    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ifu_cmd_valid,
  output logic          ifu_cmd_ready,
  input  logic [AW-1:0] ifu_cmd_addr,
  output logic          ifu_rsp_valid,
  input  logic          ifu_rsp_ready,
  output logic [DW-1:0] ifu_rsp_rdata,
  input  logic          lsu_cmd_valid,
  output logic          lsu_cmd_ready,
  input  logic          lsu_cmd_read,
  input  logic [AW-1:0] lsu_cmd_addr,
  input  logic [DW-1:0] lsu_cmd_wdata,
  input  logic [MW-1:0] lsu_cmd_wmask,
  output logic          lsu_rsp_valid,
  input  logic          lsu_rsp_ready,
  output logic [DW-1:0] lsu_rsp_rdata,
  output logic          ram_cs,
  output logic          ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [MW-1:0] ram_wem,
  output logic [DW-1:0] ram_din,
  input  logic [DW-1:0] ram_dout,
  output logic          ram_sd,
  output logic          ram_ds,
  output logic          ram_ls
);
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);

  pend_t         pend_q, pend_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          ls, rsp_hs, can_issue, lsu_win, ifu_win, grant;

  assign rsp_hs = (pend_q.st == PEND) &&
                  ((pend_q.own == OWN_LSU) ? lsu_rsp_ready : ifu_rsp_ready);

  // rst_n gates issue so nothing reaches the RAM while reset is held.
  assign can_issue = rst_n && !ls && ((pend_q.st == IDLE) || rsp_hs);
  assign lsu_win   = can_issue && lsu_cmd_valid &&
                     !(ifu_cmd_valid && (starve_q == SMAX));
  assign ifu_win   = can_issue && ifu_cmd_valid && !lsu_win;
  assign grant     = lsu_win || ifu_win;

  assign lsu_cmd_ready = lsu_win;
  assign ifu_cmd_ready = ifu_win;

  assign ram_cs   = grant;
  assign ram_we   = lsu_win && !lsu_cmd_read;
  assign ram_addr = lsu_win ? lsu_cmd_addr : ifu_cmd_addr;
  assign ram_wem  = ram_we ? lsu_cmd_wmask : '0;
  assign ram_din  = lsu_cmd_wdata;
  assign ram_sd   = 1'b0;
  assign ram_ds   = 1'b0;

  always_comb begin
    starve_d = starve_q;
    if (!ifu_cmd_valid || ifu_win)
      starve_d = '0;
    else if (lsu_win && (starve_q != SMAX))
      starve_d = starve_q + SW'(1);
  end

  always_comb begin
    pend_d = pend_q;
    if (grant) begin
      pend_d.st  = PEND;
      pend_d.own = lsu_win ? OWN_LSU : OWN_IFU;
      pend_d.rd  = ifu_win || lsu_cmd_read;
    end else if (rsp_hs) begin
      pend_d.st = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q   <= '{st: IDLE, own: OWN_IFU, rd: 1'b0};
      starve_q <= '0;
    end else begin
      pend_q   <= pend_d;
      starve_q <= starve_d;
    end
  end

  assign ifu_rsp_valid = (pend_q.st == PEND) && (pend_q.own == OWN_IFU);
  assign lsu_rsp_valid = (pend_q.st == PEND) && (pend_q.own == OWN_LSU);
  assign ifu_rsp_rdata = ifu_rsp_valid ? ram_dout : '0;
  assign lsu_rsp_rdata = (lsu_rsp_valid && pend_q.rd) ? ram_dout : '0;

  e203_itcm_ls_ctrl #(.IDLE_LS(IDLE_LS)) u_ls (
    .clk      (clk),
    .rst_n    (rst_n),
    .quiet_i  ((pend_q.st == IDLE) && !grant),
    .wake_i   (ifu_cmd_valid || lsu_cmd_valid),
    .ls_o     (ls),
    .ram_ls_o (ram_ls)
  );
endmodule

// File: doc/e203_itcm_ctrl.md
Name: e203_itcm_ctrl

Overview:
- Sequences the single-port ITCM SRAM and shares it between two requesters: IFU (instruction fetch, read-only) and LSU (load/store, read/write).
- Fixed LSU priority with an anti-starvation counter guaranteeing IFU progress.
- Routes 1-cycle-latency read data back to the winning requester and manages the SRAM light-sleep pin on idle.
- Sits between the IFU/LSU ITCM ports and the ITCM RAM macro wrapper.

Parameters:
- AW, `E203_ITCM_RAM_AW (13), RAM word-address width.
- DW, `E203_ITCM_RAM_DW (64), RAM data width.
- MW, `E203_ITCM_RAM_MW (8), byte-write-mask width (DW/8).
- STARVE_MAX, 4, consecutive LSU grants allowed while IFU waits.
- IDLE_LS, 16, idle cycles before `ls` is asserted; 0 disables light sleep.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ifu_cmd_valid  in  1  IFU read request
- ifu_cmd_ready  out  1  IFU request accepted
- ifu_cmd_addr  in  AW  IFU word address
- ifu_rsp_valid  out  1  IFU read data valid
- ifu_rsp_ready  in  1  IFU accepts data
- ifu_rsp_rdata  out  DW  IFU read data
- lsu_cmd_valid  in  1  LSU request
- lsu_cmd_ready  out  1  LSU request accepted
- lsu_cmd_read  in  1  1=read, 0=write
- lsu_cmd_addr  in  AW  LSU word address
- lsu_cmd_wdata  in  DW  write data
- lsu_cmd_wmask  in  MW  byte enables
- lsu_rsp_valid  out  1  LSU response (read data or write ack)
- lsu_rsp_ready  in  1  LSU accepts response
- lsu_rsp_rdata  out  DW  LSU read data (0 for writes)
- ram_cs, ram_we  out  1  RAM chip select, write enable
- ram_addr  out  AW  RAM address
- ram_wem  out  MW  RAM byte mask
- ram_din  out  DW  RAM write data
- ram_dout  in  DW  RAM read data, valid the cycle after cs
- ram_sd, ram_ds, ram_ls  out  1  RAM power pins

Behaviour:
- One clock. Reset is asynchronous and active-low via rst_n: clk and rst_n follow the codebase naming; polarity and synchronicity are fixed.
- Reset values:
  - all *_ready, *_rsp_valid, ram_cs, ram_we, ram_sd, ram_ds and ram_ls are 0;
  - rdata outputs are 0;
  - starve counter, idle counter and pending state are 0.
- ram_sd and ram_ds are tied to 0.
- States:
  - IDLE: no outstanding access.
  - PEND: an access was issued last cycle; its response is being presented.
  - PEND records owner (IFU/LSU) and whether the access was a read.
- Issue condition: issue when `ls`=0 AND (state==IDLE OR the current response handshakes this cycle). Otherwise both cmd_ready are 0.
  - Back-to-back accesses give 1 access/cycle when rsp_ready=1.
- Arbitration (only when the issue condition holds):
  - LSU wins if lsu_cmd_valid, unless ifu_cmd_valid and starve==STARVE_MAX, in which case IFU wins.
  - Otherwise IFU wins if ifu_cmd_valid.
  - cmd_ready goes to the winner only (combinational); the loser's ready is 0.
- Starve counter:
  - +1 on an LSU grant while ifu_cmd_valid=1 (saturating at STARVE_MAX);
  - reset to 0 on an IFU grant or when ifu_cmd_valid=0.
- RAM drive on grant (same cycle):
  - ram_cs=1; ram_we=winner write; ram_addr=winner addr; ram_wem=lsu_cmd_wmask for a write, else 0; ram_din=lsu_cmd_wdata.
  - ram_cs=0 otherwise.
- Response:
  - In PEND, owner rsp_valid=1 and rdata=ram_dout for reads, 0 for write acks.
  - rsp_valid is held until rsp_ready.
  - No cs is issued while the response is stalled, so ram_dout stays stable.
  - On handshake with no new grant, return to IDLE.
- Light sleep:
  - The idle counter increments each cycle with ram_cs=0 and state IDLE, and clears on cs.
  - ram_ls=1 once the counter reaches IDLE_LS.
  - ram_ls drops the first cycle any cmd_valid is seen. That cycle grants nothing (1-cycle wake penalty); the grant comes the next cycle.
  - ram_ls is never 1 in PEND.
- Simultaneous events:
  - Response handshake plus new requests in the same cycle: the new grant proceeds and the state stays PEND with the new owner.
  - Both requesters valid: arbitration rule above.
- Reset mid-operation: the pending response is dropped, ram_cs goes 0 immediately, and requesters must reissue.
- Address/width: no translation. Addresses pass through unmodified; mask and data widths are exact (MW*8==DW).

Decomposition:
- Shared package/defines (e203_defines): `E203_ITCM_RAM_AW/DW/MW`, owner encoding (OWN_IFU=0, OWN_LSU=1), state encoding (IDLE=0, PEND=1).
- One natural sub-module: e203_itcm_ls_ctrl, the idle counter plus ls/wake logic.
- Arbitration and response routing stay in the top module.

Test Plan:
- LSU read at addr 0x010 with rsp_ready=1 -> ram_cs=1 and we=0 in cycle t; lsu_rsp_valid=1 in t+1 with rdata equal to the RAM content; ifu_rsp_valid stays 0.
- LSU write addr 0x020, wmask 0x0F, wdata 0x1122334455667788, then a read of 0x020 -> ram_wem=0x0F; write ack rdata=0; the read returns the low 4 bytes updated and the upper bytes unchanged.
- IFU and LSU both continuously valid, STARVE_MAX=4 -> grant sequence L,L,L,L,I,L,L,L,L,I…
- lsu_rsp_ready=0 for 3 cycles while IFU is valid -> no ram_cs and ifu_cmd_ready=0 for those cycles; lsu_rdata stays stable; IFU is granted in the same cycle rsp_ready rises.
- 20 idle cycles with IDLE_LS=16 -> ram_ls=1 from cycle 16; ifu_cmd_valid at cycle 20 -> ls=0 and ready=0 at 20; grant at 21; response at 22.
- rst_n asserted while in PEND -> rsp_valid, ram_cs and ram_ls all go 0 asynchronously; after release the first request is served with normal 1-cycle latency.
